// File: rtl/video_sync_pkg.sv
// Shared types and lock thresholds for the video sync normalizer.
package video_sync_pkg;

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } lock_state_e;

   localparam int H_LOCK_LINES  = 4;
   localparam int V_LOCK_FRAMES = 2;

endpackage

// File: rtl/sync_pol_detect.sv
// Measures high/low run lengths of a sync signal between rising edges and
// decides its polarity; instanced once per axis.
module sync_pol_detect #(
   parameter int CNT_W = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             sync,
   output logic             pol,
   output logic [CNT_W:0]   total,
   output logic [CNT_W-1:0] width,
   output logic             bnd,
   output logic             invalid
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             sync_d;
   logic             armed;
   logic             rise;
   logic [CNT_W-1:0] hi_cnt;
   logic [CNT_W-1:0] lo_cnt;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   // The first rising edge after reset only arms the detector, so a partial
   // period is never evaluated.
   assign rise    = en & sync & ~sync_d;
   assign bnd     = rise & armed;
   assign total   = {1'b0, hi_cnt} + {1'b0, lo_cnt};
   assign width   = (hi_cnt < lo_cnt) ? hi_cnt : lo_cnt;
   assign invalid = bnd & ((hi_cnt == CNT_MAX) | (lo_cnt == CNT_MAX));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_d <= 1'b0;
         armed  <= 1'b0;
         hi_cnt <= '0;
         lo_cnt <= '0;
         pol    <= 1'b0;
      end else if (en) begin
         sync_d <= sync;
         if (rise) begin
            armed  <= 1'b1;
            hi_cnt <= CNT_W'(1);
            lo_cnt <= '0;
            if (bnd && !invalid) begin
               if (hi_cnt < lo_cnt) begin
                  pol <= 1'b1;
               end else if (hi_cnt > lo_cnt) begin
                  pol <= 1'b0;
               end
            end
         end else if (sync) begin
            hi_cnt <= sat_inc(hi_cnt);
         end else begin
            lo_cnt <= sat_inc(lo_cnt);
         end
      end
   end

endmodule

// File: rtl/video_sync_normalizer.sv
// Normalises core syncs to active-low, blanks RGB and reports timing lock.
// Optional VIDEO_SYNC_STATS_EN adds h_total_o, v_total_o and hs_width_o.
module video_sync_normalizer
   import video_sync_pkg::*;
#(
   parameter int COLOR_DEPTH = 6,
   parameter int HCNT_WIDTH  = 12,
   parameter int VCNT_WIDTH  = 11
) (
   input  logic                   clk_sys,
   input  logic                   reset,
   input  logic                   ce_pix,
   input  logic [COLOR_DEPTH-1:0] R,
   input  logic [COLOR_DEPTH-1:0] G,
   input  logic [COLOR_DEPTH-1:0] B,
   input  logic                   HSync,
   input  logic                   VSync,
   input  logic                   HBlank,
   input  logic                   VBlank,
   output logic [COLOR_DEPTH-1:0] R_out,
   output logic [COLOR_DEPTH-1:0] G_out,
   output logic [COLOR_DEPTH-1:0] B_out,
   output logic                   HSync_out,
   output logic                   VSync_out,
   output logic                   h_pol,
   output logic                   v_pol,
`ifdef VIDEO_SYNC_STATS_EN
   output logic [HCNT_WIDTH:0]    h_total_o,
   output logic [VCNT_WIDTH:0]    v_total_o,
   output logic [HCNT_WIDTH-1:0]  hs_width_o,
`endif
   output logic                   locked
);

   localparam logic [1:0] H_MATCH_MAX = 2'(H_LOCK_LINES - 1);
   localparam logic       V_MATCH_MAX = 1'(V_LOCK_FRAMES - 1);

   logic                  hs_d;
   logic                  line_stb;
   logic                  h_bnd, h_inv, v_bnd, v_inv;
   logic [HCNT_WIDTH:0]   h_total;
   logic [HCNT_WIDTH-1:0] h_width;
   logic [VCNT_WIDTH:0]   v_total;
   logic [VCNT_WIDTH-1:0] v_width;

   lock_state_e           state, state_n;
   logic [HCNT_WIDTH:0]   h_prev, h_prev_n;
   logic [VCNT_WIDTH:0]   v_prev, v_prev_n;
   logic                  h_pv, h_pv_n, v_pv, v_pv_n;
   logic [1:0]            h_match, h_match_n;
   logic                  v_match, v_match_n;
   logic                  h_mis, v_mis, dis;

   assign line_stb = ce_pix & HSync & ~hs_d;

   sync_pol_detect #(.CNT_W(HCNT_WIDTH)) u_h_det (
      .clk     (clk_sys),
      .rst     (reset),
      .en      (ce_pix),
      .sync    (HSync),
      .pol     (h_pol),
      .total   (h_total),
      .width   (h_width),
      .bnd     (h_bnd),
      .invalid (h_inv)
   );

   sync_pol_detect #(.CNT_W(VCNT_WIDTH)) u_v_det (
      .clk     (clk_sys),
      .rst     (reset),
      .en      (line_stb),
      .sync    (VSync),
      .pol     (v_pol),
      .total   (v_total),
      .width   (v_width),
      .bnd     (v_bnd),
      .invalid (v_inv)
   );

   // Output stage: syncs use the polarity held before this ce's update.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         hs_d      <= 1'b0;
         R_out     <= '0;
         G_out     <= '0;
         B_out     <= '0;
         HSync_out <= 1'b1;
         VSync_out <= 1'b1;
      end else if (ce_pix) begin
         hs_d      <= HSync;
         R_out     <= (HBlank | VBlank) ? '0 : R;
         G_out     <= (HBlank | VBlank) ? '0 : G;
         B_out     <= (HBlank | VBlank) ? '0 : B;
         HSync_out <= HSync ^ h_pol;
         VSync_out <= VSync ^ v_pol;
      end
   end

   always_comb begin
      h_prev_n  = h_prev;
      h_pv_n    = h_pv;
      h_match_n = h_match;
      v_prev_n  = v_prev;
      v_pv_n    = v_pv;
      v_match_n = v_match;
      state_n   = state;

      h_mis = h_bnd & (h_inv | (h_pv & (h_total != h_prev)));
      v_mis = v_bnd & (v_inv | (v_pv & (v_total != v_prev)));
      dis   = h_mis | v_mis;

      if (h_bnd) begin
         h_prev_n = h_total;
         h_pv_n   = ~h_inv;
         if (h_pv && !h_mis && (h_match != H_MATCH_MAX)) begin
            h_match_n = h_match + 2'd1;
         end
      end
      if (v_bnd) begin
         v_prev_n = v_total;
         v_pv_n   = ~v_inv;
         if (v_pv && !v_mis && (v_match != V_MATCH_MAX)) begin
            v_match_n = v_match + 1'b1;
         end
      end
      // Any disturbance on either axis restarts both match runs.
      if (dis) begin
         h_match_n = '0;
         v_match_n = 1'b0;
      end

      case (state)
         UNLOCKED: if (!dis && h_match_n == H_MATCH_MAX && v_match_n == V_MATCH_MAX) state_n = LOCKED;
         LOCKED:   if (dis) state_n = UNLOCKED;
         default:  state_n = UNLOCKED;
      endcase
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state   <= UNLOCKED;
         h_prev  <= '0;
         h_pv    <= 1'b0;
         h_match <= '0;
         v_prev  <= '0;
         v_pv    <= 1'b0;
         v_match <= 1'b0;
      end else if (ce_pix) begin
         state   <= state_n;
         h_prev  <= h_prev_n;
         h_pv    <= h_pv_n;
         h_match <= h_match_n;
         v_prev  <= v_prev_n;
         v_pv    <= v_pv_n;
         v_match <= v_match_n;
      end
   end

   assign locked = (state == LOCKED);

`ifdef VIDEO_SYNC_STATS_EN
   logic unused_width_bits;
   assign unused_width_bits = ^v_width;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         h_total_o  <= '0;
         v_total_o  <= '0;
         hs_width_o <= '0;
      end else begin
         if (h_bnd) begin
            h_total_o  <= h_total;
            hs_width_o <= h_width;
         end
         if (v_bnd) begin
            v_total_o <= v_total;
         end
      end
   end
`else
   logic unused_width_bits;
   assign unused_width_bits = ^{h_width, v_width};
`endif

endmodule

// File: tb/tb_video_sync_normalizer.sv
// Bench for video_sync_normalizer: blanking table, directed sync timings and
// randomized traffic against a run-length based reference model.
module tb_video_sync_normalizer;

   localparam int CD   = 6;
   localparam int MAXH = 4095;
   localparam int MAXV = 2047;

   logic          clk_sys = 1'b0;
   logic          reset;
   logic          ce_pix;
   logic [CD-1:0] R, G, B;
   logic          HSync, VSync, HBlank, VBlank;
   logic [CD-1:0] R_out, G_out, B_out;
   logic          HSync_out, VSync_out, h_pol, v_pol, locked;

   video_sync_normalizer dut (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .ce_pix    (ce_pix),
      .R         (R),
      .G         (G),
      .B         (B),
      .HSync     (HSync),
      .VSync     (VSync),
      .HBlank    (HBlank),
      .VBlank    (VBlank),
      .R_out     (R_out),
      .G_out     (G_out),
      .B_out     (B_out),
      .HSync_out (HSync_out),
      .VSync_out (VSync_out),
      .h_pol     (h_pol),
      .v_pol     (v_pol),
      .locked    (locked)
   );

   always #5 clk_sys = ~clk_sys;

   int n_tests = 0;
   int n_fail  = 0;

   task check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: raw sample counts between rising edges, runs of equal totals
   int          mh1, mh0, mv1, mv0;
   bit          mhs_prev, mvs_prev, mh_arm, mv_arm;
   bit          e_hp, e_vp, e_hs, e_vs, e_lk;
   logic [CD-1:0] e_r, e_g, e_b;
   int          hrun[$];
   int          vrun[$];

   task model_reset();
      mh1 = 0; mh0 = 0; mv1 = 0; mv0 = 0;
      mhs_prev = 0; mvs_prev = 0; mh_arm = 0; mv_arm = 0;
      e_hp = 0; e_vp = 0; e_hs = 1; e_vs = 1; e_lk = 0;
      e_r = '0; e_g = '0; e_b = '0;
      hrun.delete(); vrun.delete();
   endtask

   task model_eval(input int n1, input int n0, input int maxc, inout bit pol,
                   output bit inv, output int tot);
      int hi, lo;
      hi  = (n1 > maxc) ? maxc : n1;
      lo  = (n0 > maxc) ? maxc : n0;
      inv = (hi == maxc) || (lo == maxc);
      tot = hi + lo;
      if (!inv) begin
         if (hi < lo) pol = 1;
         else if (hi > lo) pol = 0;
      end
   endtask

   task model_step(input bit hs, input bit vs, input bit hb, input bit vb,
                   input logic [CD-1:0] r, input logic [CD-1:0] g, input logic [CD-1:0] b);
      bit hrise, vrise, h_ev, v_ev, h_inv, v_inv, dis;
      int h_t, v_t, keep;
      e_r  = (hb || vb) ? '0 : r;
      e_g  = (hb || vb) ? '0 : g;
      e_b  = (hb || vb) ? '0 : b;
      e_hs = hs ^ e_hp;
      e_vs = vs ^ e_vp;
      h_ev = 0; v_ev = 0; h_inv = 0; v_inv = 0; h_t = 0; v_t = 0; dis = 0;
      hrise = hs && !mhs_prev;
      mhs_prev = hs;
      if (hrise) begin
         if (mh_arm) begin model_eval(mh1, mh0, MAXH, e_hp, h_inv, h_t); h_ev = 1; end
         mh_arm = 1; mh1 = 1; mh0 = 0;
         vrise = vs && !mvs_prev;
         mvs_prev = vs;
         if (vrise) begin
            if (mv_arm) begin model_eval(mv1, mv0, MAXV, e_vp, v_inv, v_t); v_ev = 1; end
            mv_arm = 1; mv1 = 1; mv0 = 0;
         end else if (vs) mv1++;
         else mv0++;
      end else if (hs) mh1++;
      else mh0++;

      if (h_ev) begin
         if (h_inv) begin hrun.delete(); dis = 1; end
         else if (hrun.size() > 0 && hrun[$] != h_t) begin hrun.delete(); hrun.push_back(h_t); dis = 1; end
         else hrun.push_back(h_t);
      end
      if (v_ev) begin
         if (v_inv) begin vrun.delete(); dis = 1; end
         else if (vrun.size() > 0 && vrun[$] != v_t) begin vrun.delete(); vrun.push_back(v_t); dis = 1; end
         else vrun.push_back(v_t);
      end
      if (dis) begin
         if (hrun.size() > 1) begin keep = hrun[$]; hrun.delete(); hrun.push_back(keep); end
         if (vrun.size() > 1) begin keep = vrun[$]; vrun.delete(); vrun.push_back(keep); end
      end
      if (hrun.size() > 8) void'(hrun.pop_front());
      if (vrun.size() > 8) void'(vrun.pop_front());
      e_lk = (hrun.size() >= 4) && (vrun.size() >= 2);
   endtask

   task clk_step(input bit ce, input bit hs, input bit vs, input bit hb, input bit vb,
                 input logic [CD-1:0] r, input logic [CD-1:0] g, input logic [CD-1:0] b);
      ce_pix = ce; HSync = hs; VSync = vs; HBlank = hb; VBlank = vb;
      R = r; G = g; B = b;
      @(posedge clk_sys);
      if (ce) model_step(hs, vs, hb, vb, r, g, b);
      #1;
      if (n_fail < 100)
         check("outputs_vs_model",
               32'({R_out, G_out, B_out, HSync_out, VSync_out, h_pol, v_pol, locked}),
               32'({e_r, e_g, e_b, e_hs, e_vs, e_hp, e_vp, e_lk}));
   endtask

   // Timing generator
   int px, ln, cur_len, cur_hsw, cur_frame, cur_vsl, ce_mode;
   bit cur_hpol, cur_vpol;

   task idle_clk();
      clk_step(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               CD'($urandom), CD'($urandom), CD'($urandom));
   endtask

   task run_ce(input int n);
      bit hs_act, vs_act, hs, vs, hb, vb;
      for (int i = 0; i < n; i++) begin
         if (ce_mode == 1) repeat (3) idle_clk();
         if (ce_mode == 2) while ($urandom_range(0, 9) < 4) idle_clk();
         hs_act = (px < cur_hsw);
         vs_act = (ln < cur_vsl);
         hs = cur_hpol ? hs_act : !hs_act;
         vs = cur_vpol ? vs_act : !vs_act;
         hb = (px >= cur_len - 4) || (px < cur_hsw);
         vb = (ln < cur_vsl + 1);
         clk_step(1, hs, vs, hb, vb, CD'($urandom), CD'($urandom), CD'($urandom));
         px++;
         if (px >= cur_len) begin
            px = 0;
            ln++;
            if (ln >= cur_frame) ln = 0;
         end
      end
   endtask

   task do_reset();
      reset = 1; ce_pix = 0;
      repeat (2) @(posedge clk_sys);
      #1;
      reset = 0;
      model_reset();
      px = 0; ln = 0;
   endtask

   typedef struct {
      logic          hb;
      logic          vb;
      logic [CD-1:0] r, g, b;
      logic [CD-1:0] er, eg, eb;
   } vec_t;

   vec_t vt[6];
   int   low_cnt;

   initial begin
      vt[0] = '{1'b1, 1'b0, 6'h3F, 6'h3F, 6'h3F, 6'h00, 6'h00, 6'h00};
      vt[1] = '{1'b0, 1'b0, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F};
      vt[2] = '{1'b0, 1'b1, 6'h15, 6'h2A, 6'h3F, 6'h00, 6'h00, 6'h00};
      vt[3] = '{1'b1, 1'b1, 6'h01, 6'h02, 6'h03, 6'h00, 6'h00, 6'h00};
      vt[4] = '{1'b0, 1'b0, 6'h15, 6'h2A, 6'h01, 6'h15, 6'h2A, 6'h01};
      vt[5] = '{1'b0, 1'b0, 6'h00, 6'h3F, 6'h00, 6'h00, 6'h3F, 6'h00};

      reset = 1; ce_pix = 0; R = '0; G = '0; B = '0;
      HSync = 0; VSync = 0; HBlank = 0; VBlank = 0;
      model_reset();
      cur_len = 800; cur_hsw = 96; cur_frame = 1000; cur_vsl = 0;
      cur_hpol = 0; cur_vpol = 0; ce_mode = 0; px = 0; ln = 0;
      repeat (2) @(posedge clk_sys);
      #1;
      check("reset_values", 32'({R_out, G_out, B_out, HSync_out, VSync_out, h_pol, v_pol, locked}),
            32'h18);
      reset = 0;

      // RGB blanking table
      for (int i = 0; i < 6; i++) begin
         clk_step(1, 1, 1, vt[i].hb, vt[i].vb, vt[i].r, vt[i].g, vt[i].b);
         check("blank_table", 32'({R_out, G_out, B_out}), 32'({vt[i].er, vt[i].eg, vt[i].eb}));
      end

      // Active-low 800-pixel line, 96-pixel pulse
      do_reset();
      cur_len = 800; cur_hsw = 96; cur_frame = 1000; cur_vsl = 0; cur_hpol = 0; cur_vpol = 0;
      run_ce(2400);
      check("hpol_active_low", 32'(h_pol), 32'd0);
      run_ce(1);
      check("hs_delay", 32'(HSync_out), 32'(HSync));

      // Same timing, inverted HSync
      do_reset();
      cur_hpol = 1;
      run_ce(1600);
      check("hpol_active_high", 32'(h_pol), 32'd1);
      low_cnt = 0;
      for (int i = 0; i < 800; i++) begin
         run_ce(1);
         if (!HSync_out) low_cnt++;
      end
      check("hs_low_width", 32'(low_cnt), 32'd96);

      // Lock acquisition, one long line, re-lock
      do_reset();
      cur_len = 80; cur_hsw = 8; cur_frame = 10; cur_vsl = 2; cur_hpol = 0; cur_vpol = 0;
      run_ce(4 * 800);
      check("locked_steady", 32'(locked), 32'd1);
      cur_len = 81;
      run_ce(81);
      cur_len = 80;
      run_ce(cur_hsw + 1);
      check("unlock_long_line", 32'(locked), 32'd0);
      run_ce(4 * 800);
      check("relock", 32'(locked), 32'd1);

      // HSync stuck high long enough to saturate the counter
      for (int i = 0; i < 5000; i++) clk_step(1, 1, 1, 0, 0, CD'($urandom), CD'($urandom), CD'($urandom));
      px = 0;
      run_ce(cur_hsw + 1);
      check("sat_hpol_kept", 32'(h_pol), 32'd0);
      check("sat_unlock", 32'(locked), 32'd0);

      // ce_pix every 4th clock
      do_reset();
      cur_len = 40; cur_hsw = 4; cur_frame = 6; cur_vsl = 1; ce_mode = 1;
      run_ce(40 * 6 * 4);
      check("ce4_locked", 32'(locked), 32'd1);
      check("ce4_hpol", 32'(h_pol), 32'd0);
      ce_mode = 0;

      // Randomized timings, polarities and ce density
      do_reset();
      for (int seg = 0; seg < 6; seg++) begin
         cur_len   = $urandom_range(30, 70);
         cur_hsw   = $urandom_range(3, cur_len / 3);
         cur_frame = $urandom_range(4, 8);
         cur_vsl   = $urandom_range(1, 2);
         cur_hpol  = 1'($urandom);
         cur_vpol  = 1'($urandom);
         ce_mode   = 2;
         run_ce(cur_len * cur_frame * 3);
      end
      ce_mode = 0;

      // Reset asserted mid-line
      run_ce(25);
      #2;
      reset = 1;
      #1;
      check("midline_reset", 32'({R_out, G_out, B_out, HSync_out, VSync_out, h_pol, v_pol, locked}),
            32'h18);
      @(posedge clk_sys);
      #1;
      reset = 0;
      model_reset();
      px = 0; ln = 0;
      run_ce(10);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
